// File: rtl/panel_cmd_engine.sv
// Byte-stream command decoder for an LED panel frame buffer: sets channel/brightness
// enables, writes single rows, fills the whole frame with a pattern and flips buffers.
module panel_cmd_engine #(
  parameter int unsigned PIXEL_WIDTH     = 64,
  parameter int unsigned PIXEL_HEIGHT    = 32,
  parameter int unsigned BYTES_PER_PIXEL = 2,
  parameter int unsigned BRIGHTNESS_BITS = 6,
  parameter int unsigned TIMEOUT_TICKS   = 65535,
  localparam int unsigned ROW_BYTES      = PIXEL_WIDTH * BYTES_PER_PIXEL,
  localparam int unsigned ADDR_W         = $clog2(PIXEL_HEIGHT) + $clog2(ROW_BYTES)
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic [7:0]                 data_rx,
  input  logic                       data_valid,
  output logic [ADDR_W-1:0]          ram_address,
  output logic [7:0]                 ram_data_out,
  output logic                       ram_write_enable,
  output logic                       frame_select,
  output logic [2:0]                 rgb_enable,
  output logic [BRIGHTNESS_BITS-1:0] brightness_enable,
  output logic                       busy,
  output logic                       cmd_error,
  output logic [7:0]                 num_commands_processed
);

  localparam int unsigned ColBits = $clog2(ROW_BYTES);
  localparam int unsigned RowW    = ($clog2(PIXEL_HEIGHT) > 0) ? $clog2(PIXEL_HEIGHT) : 1;
  localparam int unsigned ColW    = (ColBits > 0) ? ColBits : 1;
  localparam int unsigned PbW     = ($clog2(BYTES_PER_PIXEL) > 0) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int unsigned TmoW    = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StArg,
    StRowSel,
    StRowData,
    StFillArg,
    StFill
  } state_e;

  state_e                                state_q, state_d;
  logic [RowW-1:0]                       row_q, row_d;
  logic [ColW-1:0]                       col_q, col_d;
  logic [PbW-1:0]                        pb_q, pb_d;
  logic [BYTES_PER_PIXEL-1:0][7:0]       pat_q, pat_d;
  logic [TmoW-1:0]                       tmo_q, tmo_d;
  logic                                  arg_bri_q, arg_bri_d;
  logic [2:0]                            rgb_q, rgb_d;
  logic [BRIGHTNESS_BITS-1:0]            bri_q, bri_d;
  logic                                  fs_q, fs_d;
  logic                                  we_q, we_d;
  logic [ADDR_W-1:0]                     addr_q, addr_d;
  logic [7:0]                            wdata_q, wdata_d;
  logic                                  err_q, err_d;
  logic [7:0]                            cnt_q, cnt_d;
  logic                                  done;
  logic                                  last_col, last_row, last_pb;
  logic [ADDR_W-1:0]                     cur_addr;

  assign last_col = (col_q == ColW'(ROW_BYTES - 1));
  assign last_row = (row_q == RowW'(PIXEL_HEIGHT - 1));
  assign last_pb  = (pb_q == PbW'(BYTES_PER_PIXEL - 1));
  assign cur_addr = (ADDR_W'(row_q) << ColBits) | ADDR_W'(col_q);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    pb_d      = pb_q;
    pat_d     = pat_q;
    tmo_d     = '0;
    arg_bri_d = arg_bri_q;
    rgb_d     = rgb_q;
    bri_d     = bri_q;
    fs_d      = fs_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = 1'b0;
    done      = 1'b0;

    // Inter-byte timeout applies to every state that is waiting for an argument byte.
    if (state_q inside {StArg, StRowSel, StRowData, StFillArg} && !data_valid) begin
      if (tmo_q == TmoW'(TIMEOUT_TICKS - 1)) begin
        err_d   = 1'b1;
        state_d = StIdle;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (data_valid) begin
          case (data_rx)
            8'h52: begin arg_bri_d = 1'b0; state_d = StArg; end
            8'h42: begin arg_bri_d = 1'b1; state_d = StArg; end
            8'h4C: state_d = StRowSel;
            8'h46: begin pb_d = '0; state_d = StFillArg; end
            8'h5A: begin fs_d = ~fs_q; done = 1'b1; end
            default: err_d = 1'b1;
          endcase
        end
      end
      StArg: begin
        if (data_valid) begin
          if (arg_bri_q) bri_d = data_rx[BRIGHTNESS_BITS-1:0];
          else           rgb_d = data_rx[2:0];
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      StRowSel: begin
        if (data_valid) begin
          if (32'(data_rx) < PIXEL_HEIGHT) begin
            row_d   = RowW'(data_rx);
            col_d   = '0;
            state_d = StRowData;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StRowData: begin
        if (data_valid) begin
          we_d    = 1'b1;
          addr_d  = cur_addr;
          wdata_d = data_rx;
          col_d   = col_q + 1'b1;
          if (last_col) begin
            done    = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StFillArg: begin
        if (data_valid) begin
          pat_d[pb_q] = data_rx;
          if (last_pb) begin
            pb_d    = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = StFill;
          end else begin
            pb_d = pb_q + 1'b1;
          end
        end
      end
      StFill: begin
        // Bytes arriving mid-fill are dropped; the fill itself runs to completion.
        if (data_valid) err_d = 1'b1;
        we_d    = 1'b1;
        addr_d  = cur_addr;
        wdata_d = pat_q[pb_q];
        pb_d    = last_pb ? '0 : pb_q + 1'b1;
        if (last_col) begin
          col_d = '0;
          if (last_row) begin
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    cnt_d = (done && !err_d) ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      row_q     <= '0;
      col_q     <= '0;
      pb_q      <= '0;
      pat_q     <= '0;
      tmo_q     <= '0;
      arg_bri_q <= 1'b0;
      rgb_q     <= 3'b111;
      bri_q     <= '1;
      fs_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      pb_q      <= pb_d;
      pat_q     <= pat_d;
      tmo_q     <= tmo_d;
      arg_bri_q <= arg_bri_d;
      rgb_q     <= rgb_d;
      bri_q     <= bri_d;
      fs_q      <= fs_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ram_address            = addr_q;
  assign ram_data_out           = wdata_q;
  assign ram_write_enable       = we_q;
  assign frame_select           = fs_q;
  assign rgb_enable             = rgb_q;
  assign brightness_enable      = bri_q;
  assign busy                   = (state_q != StIdle);
  assign cmd_error              = err_q;
  assign num_commands_processed = cnt_q;

endmodule

// File: tb/tb_panel_cmd_engine.sv
// Directed bench for panel_cmd_engine on a 4x2 panel, 2 bytes/pixel, 16-cycle timeout.
module tb_panel_cmd_engine;

  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst;
  logic [7:0]    din;
  logic          dv;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_data_out;
  logic          ram_write_enable;
  logic          frame_select;
  logic [2:0]    rgb_enable;
  logic [5:0]    brightness_enable;
  logic          busy;
  logic          cmd_error;
  logic [7:0]    num_commands_processed;

  panel_cmd_engine #(
    .PIXEL_WIDTH    (4),
    .PIXEL_HEIGHT   (2),
    .BYTES_PER_PIXEL(2),
    .BRIGHTNESS_BITS(6),
    .TIMEOUT_TICKS  (16)
  ) dut (
    .clk_in                (clk),
    .reset                 (rst),
    .data_rx               (din),
    .data_valid            (dv),
    .ram_address           (ram_address),
    .ram_data_out          (ram_data_out),
    .ram_write_enable      (ram_write_enable),
    .frame_select          (frame_select),
    .rgb_enable            (rgb_enable),
    .brightness_enable     (brightness_enable),
    .busy                  (busy),
    .cmd_error             (cmd_error),
    .num_commands_processed(num_commands_processed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Write/error capture, sampled on the falling edge.
  int         cyc = 0;
  int         wr_n = 0;
  int         err_n = 0;
  logic [3:0] wr_addr [64];
  logic [7:0] wr_data [64];
  int         wr_cyc  [64];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ram_write_enable === 1'b1) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = ram_address;
        wr_data[wr_n] = ram_data_out;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n = wr_n + 1;
    end
    if (cmd_error === 1'b1) err_n = err_n + 1;
  end

  typedef struct {
    logic [7:0] din;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wd;
    logic       err;
    logic       busy;
    logic [7:0] cnt;
    logic       fs;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    tick();
    din = b;
    dv  = 1'b1;
    tick();
    dv  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dv  = 1'b0;
    din = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    wr_n  = 0;
    err_n = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " we"},   ram_write_enable, 0);
    check({tag, " addr"}, ram_address, 0);
    check({tag, " data"}, ram_data_out, 0);
    check({tag, " fs"},   frame_select, 0);
    check({tag, " rgb"},  rgb_enable, 3'b111);
    check({tag, " bri"},  brightness_enable, 6'h3F);
    check({tag, " busy"}, busy, 0);
    check({tag, " err"},  cmd_error, 0);
    check({tag, " cnt"},  num_commands_processed, 0);
  endtask

  initial begin
    int  snap;
    bit  found;
    bit  injected;

    vecs[0]  = '{8'h52, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 8'd0, 1'b0};
    vecs[1]  = '{8'h05, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[2]  = '{8'h42, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 8'd1, 1'b0};
    vecs[3]  = '{8'h2A, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'd2, 1'b0};
    vecs[4]  = '{8'h4C, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 8'd2, 1'b0};
    vecs[5]  = '{8'h01, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 8'd2, 1'b0};
    for (int k = 0; k < 8; k++) begin
      vecs[6+k] = '{8'(16 + k), 1'b1, 4'(8 + k), 8'(16 + k), 1'b0, (k != 7),
                    (k == 7) ? 8'd3 : 8'd2, 1'b0};
    end
    vecs[14] = '{8'h4C, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 8'd3, 1'b0};
    vecs[15] = '{8'h02, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'd3, 1'b0};
    vecs[16] = '{8'h51, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'd3, 1'b0};
    vecs[17] = '{8'h5A, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'd4, 1'b1};
    vecs[18] = '{8'h5A, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'd5, 1'b0};

    rst = 1'b1;
    dv  = 1'b0;
    din = 8'h00;
    tick();
    check_reset_outputs("reset");
    do_reset();

    // Enables, one row write, bad row, unknown opcode, two frame swaps.
    for (int i = 0; i < 19; i++) begin
      send(vecs[i].din);
      check($sformatf("v%0d we", i), ram_write_enable, vecs[i].we);
      if (vecs[i].we) begin
        check($sformatf("v%0d addr", i), ram_address, vecs[i].addr);
        check($sformatf("v%0d wdata", i), ram_data_out, vecs[i].wd);
      end
      check($sformatf("v%0d err", i), cmd_error, vecs[i].err);
      check($sformatf("v%0d busy", i), busy, vecs[i].busy);
      check($sformatf("v%0d cnt", i), num_commands_processed, vecs[i].cnt);
      check($sformatf("v%0d fs", i), frame_select, vecs[i].fs);
    end
    check("table rgb", rgb_enable, 3'b101);
    check("table bri", brightness_enable, 6'h2A);
    check("table writes", wr_n, 8);

    // Fill with a byte injected mid-fill.
    do_reset();
    send(8'h46);
    send(8'hAA);
    send(8'h55);
    injected = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (!injected && wr_n == 6) begin
        din = 8'h99;
        dv  = 1'b1;
        injected = 1'b1;
      end else begin
        dv = 1'b0;
      end
      tick();
    end
    dv = 1'b0;
    check("fill injected", injected, 1);
    check("fill writes", wr_n, 16);
    for (int i = 0; i < 16 && i < wr_n; i++) begin
      check($sformatf("fill addr%0d", i), wr_addr[i], i);
      check($sformatf("fill data%0d", i), wr_data[i], (i % 2 == 0) ? 8'hAA : 8'h55);
      check($sformatf("fill cyc%0d", i), wr_cyc[i] - wr_cyc[0], i);
    end
    check("fill err pulses", err_n, 1);
    check("fill cnt", num_commands_processed, 1);
    check("fill busy", busy, 0);

    // Row write abandoned by timeout.
    do_reset();
    send(8'h4C);
    send(8'h00);
    send(8'h01);
    send(8'h02);
    repeat (15) tick();
    check("tmo busy before", busy, 1);
    check("tmo err before", err_n, 0);
    tick();
    check("tmo err pulse", cmd_error, 1);
    check("tmo busy after", busy, 0);
    check("tmo writes", wr_n, 2);
    check("tmo addr0", wr_addr[0], 0);
    check("tmo data0", wr_data[0], 8'h01);
    check("tmo addr1", wr_addr[1], 1);
    check("tmo data1", wr_data[1], 8'h02);
    send(8'h52);
    send(8'h07);
    check("tmo next rgb", rgb_enable, 3'b111);
    check("tmo cnt", num_commands_processed, 1);
    check("tmo err total", err_n, 1);

    // Reset during fill at address 5.
    do_reset();
    send(8'h52);
    send(8'h02);
    send(8'h46);
    send(8'h12);
    send(8'h34);
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      if (ram_write_enable === 1'b1 && ram_address == 4'd5) found = 1'b1;
      else tick();
    end
    check("rstfill reached addr5", found, 1);
    snap = wr_n;
    rst  = 1'b1;
    #1;
    check_reset_outputs("rstfill");
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rstfill no writes", wr_n, snap);
    check("rstfill idle", busy, 0);
    send(8'h52);
    send(8'h03);
    check("rstfill opcode rgb", rgb_enable, 3'b011);
    check("rstfill opcode cnt", num_commands_processed, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
